// File: rtl/rs232_cmd_parser.sv
// RS-232 debug command parser: turns framed 'W'/'R' byte packets into host memory cycles.
// Define RS232_CMD_ACK_EN to return 0x06 after writes and 0x15 on aborted or unknown commands.
module rs232_cmd_parser #(
   parameter int unsigned DEBUG_RST_ADR = 4096,
   parameter int unsigned RD_LAT        = 2,
   parameter int unsigned IDLE_TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_full,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   output logic        host_wr_ena,
   output logic [19:0] host_addr,
   output logic [7:0]  host_wdata,
   input  logic [7:0]  host_rdata,
   output logic        busy,
   output logic        err_pulse
);

   localparam int unsigned AW = 20;
   localparam int unsigned CW = 9;
   localparam int unsigned TW = 24;
   localparam int unsigned LW = 4;

   localparam logic [7:0]    CMD_W    = 8'h57;
   localparam logic [7:0]    CMD_R    = 8'h52;
   localparam logic [AW-1:0] RST_ADR  = AW'(DEBUG_RST_ADR);
   localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
`ifdef RS232_CMD_ACK_EN
   localparam logic [7:0]    ACK_BYTE = 8'h06;
   localparam logic [7:0]    NAK_BYTE = 8'h15;
`endif

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADR2,
      ST_ADR1,
      ST_ADR0,
      ST_LEN,
      ST_WDATA,
      ST_RD_WAIT,
`ifdef RS232_CMD_ACK_EN
      ST_ACK,
`endif
      ST_RD_PUSH
   } state_t;

   state_t          state;
   logic            is_wr;
   logic [3:0]      adr_hi;
   logic [7:0]      adr_mid;
   logic [CW-1:0]   remaining;
   logic [LW-1:0]   lat_cnt;
   logic [7:0]      rd_byte;
   logic [TW-1:0]   tmo_cnt;
   logic            tmo_state_c;
   logic            tmo_hit_c;

   // Only the packet-receiving states can stall waiting for the host PC.
   assign tmo_state_c = (state == ST_ADR2) || (state == ST_ADR1) || (state == ST_ADR0) ||
                        (state == ST_LEN)  || (state == ST_WDATA);
   assign tmo_hit_c   = tmo_state_c && !rx_valid && (tmo_cnt == TMO_LAST);

   task automatic go(input state_t nxt);
      state <= nxt;
      busy  <= (nxt != ST_IDLE);
   endtask

   task automatic reject();
      err_pulse <= 1'b1;
`ifdef RS232_CMD_ACK_EN
      if (!tx_full) begin
         tx_wr   <= 1'b1;
         tx_data <= NAK_BYTE;
      end
`endif
   endtask

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         tx_wr       <= 1'b0;
         tx_data     <= 8'h00;
         host_wr_ena <= 1'b0;
         host_wdata  <= 8'h00;
         host_addr   <= RST_ADR;
         err_pulse   <= 1'b0;
         is_wr       <= 1'b0;
         adr_hi      <= 4'h0;
         adr_mid     <= 8'h00;
         remaining   <= '0;
         lat_cnt     <= '0;
         rd_byte     <= 8'h00;
         tmo_cnt     <= '0;
      end else begin
         tx_wr       <= 1'b0;
         host_wr_ena <= 1'b0;
         err_pulse   <= 1'b0;

         // Post-increment after each host write strobe, wrapping at 20 bits.
         if (host_wr_ena) host_addr <= host_addr + AW'(1);

         if (rx_valid || !tmo_state_c) tmo_cnt <= '0;
         else                          tmo_cnt <= tmo_cnt + TW'(1);

         if (tmo_hit_c) begin
            reject();
            go(ST_IDLE);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_valid) begin
                     if ((rx_data == CMD_W) || (rx_data == CMD_R)) begin
                        is_wr <= (rx_data == CMD_W);
                        go(ST_ADR2);
                     end else begin
                        reject();
                     end
                  end
               end
               ST_ADR2: begin
                  if (rx_valid) begin
                     adr_hi <= rx_data[3:0];
                     go(ST_ADR1);
                  end
               end
               ST_ADR1: begin
                  if (rx_valid) begin
                     adr_mid <= rx_data;
                     go(ST_ADR0);
                  end
               end
               ST_ADR0: begin
                  if (rx_valid) begin
                     host_addr <= {adr_hi, adr_mid, rx_data};
                     go(ST_LEN);
                  end
               end
               ST_LEN: begin
                  if (rx_valid) begin
                     remaining <= CW'(rx_data) + CW'(1);
                     lat_cnt   <= '0;
                     go(is_wr ? ST_WDATA : ST_RD_WAIT);
                  end
               end
               ST_WDATA: begin
                  if (rx_valid) begin
                     host_wdata  <= rx_data;
                     host_wr_ena <= 1'b1;
                     remaining   <= remaining - CW'(1);
                     if (remaining == CW'(1)) begin
`ifdef RS232_CMD_ACK_EN
                        go(ST_ACK);
`else
                        go(ST_IDLE);
`endif
                     end
                  end
               end
               ST_RD_WAIT: begin
                  // Address has been stable for RD_LAT cycles once lat_cnt reaches its last value.
                  if (lat_cnt == LAT_LAST) begin
                     rd_byte <= host_rdata;
                     go(ST_RD_PUSH);
                  end else begin
                     lat_cnt <= lat_cnt + LW'(1);
                  end
               end
               ST_RD_PUSH: begin
                  if (!tx_full) begin
                     tx_wr     <= 1'b1;
                     tx_data   <= rd_byte;
                     host_addr <= host_addr + AW'(1);
                     remaining <= remaining - CW'(1);
                     lat_cnt   <= '0;
                     go((remaining == CW'(1)) ? ST_IDLE : ST_RD_WAIT);
                  end
               end
`ifdef RS232_CMD_ACK_EN
               ST_ACK: begin
                  if (!tx_full) begin
                     tx_wr   <= 1'b1;
                     tx_data <= ACK_BYTE;
                     go(ST_IDLE);
                  end
               end
`endif
               default: go(ST_IDLE);
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rs232_cmd_parser.sv
// Self-checking bench for rs232_cmd_parser: directed vector table, hand sequences and random packets
// checked against a packet-level memory model. Follows RS232_CMD_ACK_EN when defined.
module tb_rs232_cmd_parser;

   localparam int unsigned RST_ADR = 4096;
   localparam int unsigned RD_LAT  = 2;
   localparam int unsigned TMO     = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_full = 1'b0;
   logic        tx_wr;
   logic [7:0]  tx_data;
   logic        host_wr_ena;
   logic [19:0] host_addr;
   logic [7:0]  host_wdata;
   logic [7:0]  host_rdata;
   logic        busy;
   logic        err_pulse;

   always #5 clk = ~clk;

   rs232_cmd_parser #(
      .DEBUG_RST_ADR(RST_ADR),
      .RD_LAT       (RD_LAT),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_full    (tx_full),
      .tx_wr      (tx_wr),
      .tx_data    (tx_data),
      .host_wr_ena(host_wr_ena),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .busy       (busy),
      .err_pulse  (err_pulse)
   );

   // Host memory as seen by the DUT (hmem) and the packet-level reference (mmem).
   logic [7:0]  hmem [0:1048575];
   logic [7:0]  mmem [0:1048575];
   logic [19:0] rd_addr_q;
   logic [19:0] model_addr;

   // RD_LAT=2: data for an address is readable two edges after it appears.
   always @(posedge clk) rd_addr_q <= host_addr;
   assign host_rdata = hmem[rd_addr_q];

   logic [19:0] wr_a [$];
   logic [7:0]  wr_d [$];
   logic [7:0]  tx_q [$];
   int          err_cnt   = 0;
   int          viol_cnt  = 0;
   int          full_mode = 0;
   logic        full_q    = 1'b0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   always @(negedge clk) begin
      if (tx_wr && full_q)      viol_cnt++;
      if (tx_wr && host_wr_ena) viol_cnt++;
      if (host_wr_ena) begin
         wr_a.push_back(host_addr);
         wr_d.push_back(host_wdata);
      end
      if (tx_wr)     tx_q.push_back(tx_data);
      if (err_pulse) err_cnt++;
      case (full_mode)
         0:       tx_full = 1'b0;
         1:       tx_full = ($urandom_range(3, 0) == 0);
         default: tx_full = 1'b1;
      endcase
      full_q = tx_full;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
      check({tag, "_idle"}, longint'(busy), 0);
   endtask

   task automatic commit_writes(input int wb);
      for (int i = wb; i < wr_a.size(); i++) hmem[wr_a[i]] = wr_d[i];
   endtask

   task automatic do_packet(input string tag, input logic [7:0] cmd, input logic [3:0] a2hi,
                            input logic [19:0] a, input logic [7:0] len, input logic [7:0] dbase,
                            input bit rnd, input int gmin, input int gmax);
      int          wb = wr_a.size();
      int          tb = tx_q.size();
      int          eb = err_cnt;
      int          n  = int'(len) + 1;
      int          bz = 0;
      bit          is_w = (cmd == 8'h57);
      bit          ok   = (cmd == 8'h57) || (cmd == 8'h52);
      logic [7:0]  d;
      logic [19:0] ea [$];
      logic [7:0]  ed [$];
      logic [7:0]  et [$];
      send_byte(cmd, $urandom_range(gmax, gmin));
      if (ok) begin
         send_byte({a2hi, a[19:16]}, $urandom_range(gmax, gmin));
         send_byte(a[15:8], $urandom_range(gmax, gmin));
         send_byte(a[7:0], $urandom_range(gmax, gmin));
         send_byte(len, $urandom_range(gmax, gmin));
         for (int i = 0; i < n; i++) begin
            if (is_w) begin
               d = rnd ? 8'($urandom) : dbase + 8'(i * 17);
               ea.push_back(a + 20'(i));
               ed.push_back(d);
               mmem[a + 20'(i)] = d;
               send_byte(d, $urandom_range(gmax, gmin));
            end else begin
               et.push_back(mmem[a + 20'(i)]);
            end
         end
`ifdef RS232_CMD_ACK_EN
         if (is_w) et.push_back(8'h06);
`endif
         model_addr = a + 20'(n);
      end else begin
`ifdef RS232_CMD_ACK_EN
         et.push_back(8'h15);
`endif
         repeat (3) begin
            if (busy) bz++;
            @(negedge clk);
         end
         check({tag, "_busy_bad"}, bz, 0);
      end
      wait_idle(tag);
      repeat (4) @(negedge clk);
      check({tag, "_nwr"}, wr_a.size() - wb, ea.size());
      for (int i = 0; i < ea.size() && wb + i < wr_a.size(); i++) begin
         check($sformatf("%s_wa%0d", tag, i), wr_a[wb + i], ea[i]);
         check($sformatf("%s_wd%0d", tag, i), wr_d[wb + i], ed[i]);
      end
      check({tag, "_ntx"}, tx_q.size() - tb, et.size());
      for (int i = 0; i < et.size() && tb + i < tx_q.size(); i++)
         check($sformatf("%s_tx%0d", tag, i), tx_q[tb + i], et[i]);
      check({tag, "_addr"}, host_addr, model_addr);
      check({tag, "_err"}, err_cnt - eb, ok ? 0 : 1);
      commit_writes(wb);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [3:0]  a2hi;
      logic [19:0] adr;
      logic [7:0]  len;
      logic [7:0]  dbase;
      logic [19:0] exp_addr;
      int          exp_err;
   } vec_t;

   vec_t vt [6];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      int wb, tb, eb, k;
      vt[0] = '{8'h57, 4'h0, 20'h01000, 8'h02, 8'hAA, 20'h01003, 0};
      vt[1] = '{8'h52, 4'h0, 20'hFFFFE, 8'h02, 8'h00, 20'h00001, 0};
      vt[2] = '{8'h41, 4'h0, 20'h00000, 8'h00, 8'h00, 20'h00001, 1};
      vt[3] = '{8'h57, 4'hA, 20'hFFFFF, 8'h01, 8'h3C, 20'h00001, 0};
      vt[4] = '{8'h52, 4'h5, 20'hFFFFF, 8'h00, 8'h00, 20'h00000, 0};
      vt[5] = '{8'h00, 4'h0, 20'h00000, 8'h00, 8'h00, 20'h00000, 1};

      for (int i = 0; i < 1048576; i++) begin
         hmem[i] = 8'(i * 7 + 3);
         mmem[i] = 8'(i * 7 + 3);
      end
      hmem[20'hFFFFE] = 8'h11; mmem[20'hFFFFE] = 8'h11;
      hmem[20'hFFFFF] = 8'h22; mmem[20'hFFFFF] = 8'h22;
      hmem[20'h00000] = 8'h33; mmem[20'h00000] = 8'h33;

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_addr", host_addr, 20'h01000);
      check("rst_busy", busy, 0);
      check("rst_txwr", tx_wr, 0);
      check("rst_txdata", tx_data, 0);
      check("rst_wren", host_wr_ena, 0);
      check("rst_wdata", host_wdata, 0);
      check("rst_err", err_pulse, 0);
      rst = 1'b0;
      @(negedge clk);
      model_addr = 20'h01000;

      // Directed vector table
      for (int v = 0; v < 6; v++) begin
         do_packet($sformatf("vec%0d", v), vt[v].cmd, vt[v].a2hi, vt[v].adr, vt[v].len,
                   vt[v].dbase, 1'b0, 0, 2);
         check($sformatf("vec%0d_tab_addr", v), host_addr, vt[v].exp_addr);
      end

      // Backpressure: TX FIFO full for 50 cycles after the first read byte
      tb = tx_q.size();
      send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
      send_byte(8'h00, 0); send_byte(8'h03, 0);
      for (k = 0; k < 200 && tx_q.size() == tb; k++) @(negedge clk);
      full_mode = 2;
      repeat (50) @(negedge clk);
      check("bp_hold_ntx", tx_q.size() - tb, 1);
      full_mode = 0;
      wait_idle("bp");
      repeat (4) @(negedge clk);
      check("bp_ntx", tx_q.size() - tb, 4);
      for (int i = 0; i < 4 && tb + i < tx_q.size(); i++)
         check($sformatf("bp_tx%0d", i), tx_q[tb + i], mmem[20'h02000 + 20'(i)]);
      model_addr = 20'h02004;
      check("bp_addr", host_addr, model_addr);

      // Timeout abort after 'W' and one address byte
      wb = wr_a.size(); tb = tx_q.size(); eb = err_cnt;
      send_byte(8'h57, 0); send_byte(8'h00, 0);
      for (k = 1; k <= int'(TMO) + 8; k++) begin
         if (err_pulse) break;
         @(negedge clk);
      end
      check("tmo_cycle_ok", (k >= int'(TMO) - 1 && k <= int'(TMO) + 1) ? 1 : 0, 1);
      repeat (4) @(negedge clk);
      check("tmo_busy", busy, 0);
      check("tmo_err", err_cnt - eb, 1);
      check("tmo_nwr", wr_a.size() - wb, 0);
      check("tmo_addr", host_addr, model_addr);
`ifdef RS232_CMD_ACK_EN
      check("tmo_ntx", tx_q.size() - tb, 1);
      if (tx_q.size() > tb) check("tmo_nak", tx_q[tb], 8'h15);
`else
      check("tmo_ntx", tx_q.size() - tb, 0);
`endif

      // Slow but in-time bytes must never time out
      do_packet("slow", 8'h57, 4'h0, 20'h04000, 8'h01, 8'h5A, 1'b0, int'(TMO) - 2, int'(TMO) - 2);

      // Maximum burst: 256 writes
      do_packet("max", 8'h57, 4'h0, 20'h00000, 8'hFF, 8'h00, 1'b1, 0, 0);
      do_packet("maxrd", 8'h52, 4'h0, 20'h000FE, 8'h03, 8'h00, 1'b0, 0, 0);

      // Reset after the 100th data byte of a max burst
      wb = wr_a.size(); tb = tx_q.size();
      send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h30, 0);
      send_byte(8'h00, 0); send_byte(8'hFF, 0);
      for (int i = 0; i < 100; i++) begin
         mmem[20'h03000 + 20'(i)] = 8'(i + 1);
         send_byte(8'(i + 1), 0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      eb = err_cnt;
      repeat (10) @(negedge clk);
      check("rstm_nwr", wr_a.size() - wb, 100);
      check("rstm_ntx", tx_q.size() - tb, 0);
      check("rstm_err", err_cnt - eb, 0);
      check("rstm_busy", busy, 0);
      check("rstm_addr", host_addr, 20'h01000);
      commit_writes(wb);
      model_addr = 20'h01000;

      // Random packets
      for (int r = 0; r < 25; r++) begin
         logic [7:0]  c;
         logic [19:0] a;
         c = ($urandom_range(1, 0) == 0) ? 8'h57 : 8'h52;
         a = ($urandom_range(1, 0) == 0) ? 20'hFFFF0 + 20'($urandom_range(15, 0)) : 20'($urandom);
         if ($urandom_range(7, 0) == 0) begin
            c = 8'($urandom);
            if (c == 8'h57 || c == 8'h52) c = 8'h00;
            full_mode = 0;
         end else begin
            full_mode = 1;
         end
         do_packet($sformatf("rnd%0d", r), c, 4'($urandom), a, 8'($urandom_range(15, 0)),
                   8'h00, 1'b1, 0, 2);
      end
      full_mode = 0;
      repeat (2) @(negedge clk);

      check("interlock_viol", viol_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
